// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the handshaked pipeline stage register.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_MAIN, PS_BOTH} pipe_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [3:0] alu_op;
  } ControlSignals;

  localparam int unsigned PS_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage entry: payload plus error flag, load-enabled, async active-low clear.
module pipe_entry_reg #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with optional skid entry, flush, sticky error flag
// and saturating stall counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned WIDTH = PS_DEFAULT_WIDTH,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_err,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             err_seen,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned EW = WIDTH + 1;

  pipe_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             err_seen_q, err_seen_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [EW-1:0]    main_q, main_d, skid_q;
  logic             main_load, skid_load;
  logic             accept, xfer;

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q[WIDTH-1:0];
  assign out_err   = main_q[WIDTH];
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign err_seen  = err_seen_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d   = state_q;
    main_d    = {in_err, in_data};
    main_load = 1'b0;
    skid_load = 1'b0;
    unique case (state_q)
      PS_EMPTY: begin
        if (accept) begin
          state_d   = PS_MAIN;
          main_load = 1'b1;
        end
      end
      PS_MAIN: begin
        // Without a skid entry, accept while full implies a transfer.
        if (accept && xfer) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = PS_BOTH;
          skid_load = 1'b1;
        end else if (xfer) begin
          state_d = PS_EMPTY;
        end
      end
      PS_BOTH: begin
        if (xfer) begin
          state_d   = PS_MAIN;
          main_d    = skid_q;
          main_load = 1'b1;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    // Flush only drops validity; payload registers keep their contents.
    if (flush) begin
      state_d   = PS_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
    in_ready_d  = (state_d != PS_BOTH);
    err_seen_d  = err_seen_q | (xfer & out_err);
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PS_EMPTY;
      in_ready_q  <= 1'b1;
      err_seen_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      err_seen_q  <= err_seen_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_entry_reg #(.W(EW)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .d       (main_d),
    .q       (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.W(EW)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (skid_load),
        .d       ({in_err, in_data}),
        .q       (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: SKID=0 (index 0) and SKID=1 (index 1) stages, WIDTH=8, CNT_W=3.
module tb_pipe_stage_skid;

  logic       clk;
  logic       reset_n;
  logic       iv[2], ir[2], ie[2], fl[2], ov[2], ordy[2], oe[2], es[2];
  logic [7:0] id[2], od[2];
  logic [2:0] sc[2];

  logic [8:0]  expq[2][$];
  logic        m_err[2];
  int unsigned m_stall[2];
  int          checks, passes;

  pipe_stage_skid #(.WIDTH(8), .SKID(0), .CNT_W(3)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .in_err(ie[0]), .flush(fl[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]), .out_err(oe[0]),
    .err_seen(es[0]), .stall_cnt(sc[0])
  );

  pipe_stage_skid #(.WIDTH(8), .SKID(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .in_err(ie[1]), .flush(fl[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]), .out_err(oe[1]),
    .err_seen(es[1]), .stall_cnt(sc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
  endtask

  // Monitor: compares DUT outputs against the queue model 3 time units after each negedge.
  initial begin
    int n;
    logic [8:0] front;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      #3;
      for (int d = 0; d < 2; d++) begin
        n = expq[d].size();
        if (!reset_n) begin
          chk("rst_out_valid", d, 32'(ov[d]), 32'd0);
          chk("rst_in_ready",  d, 32'(ir[d]), 32'd1);
          chk("rst_out_data",  d, 32'(od[d]), 32'd0);
          chk("rst_out_err",   d, 32'(oe[d]), 32'd0);
          chk("rst_err_seen",  d, 32'(es[d]), 32'd0);
          chk("rst_stall_cnt", d, 32'(sc[d]), 32'd0);
        end else begin
          exp_rdy = (d == 1) ? (n < 2) : ((n == 0) || ordy[d]);
          chk("out_valid", d, 32'(ov[d]), 32'(n != 0));
          chk("in_ready",  d, 32'(ir[d]), 32'(exp_rdy));
          chk("err_seen",  d, 32'(es[d]), 32'(m_err[d]));
          chk("stall_cnt", d, 32'(sc[d]), m_stall[d]);
          if (n != 0) begin
            front = expq[d][0];
            chk("out_data", d, 32'(od[d]), 32'(front[7:0]));
            chk("out_err",  d, 32'(oe[d]), 32'(front[8]));
            if (ordy[d]) begin
              void'(expq[d].pop_front());
              if (front[8]) m_err[d] = 1'b1;
            end else if (m_stall[d] < 7) begin
              m_stall[d]++;
            end
          end
        end
      end
    end
  end

  task automatic set_in(input int d, input logic v, input logic [7:0] data,
                        input logic e, input logic r, input logic f);
    iv[d] = v; id[d] = data; ie[d] = e; ordy[d] = r; fl[d] = f;
  endtask

  task automatic set_both(input logic v, input logic [7:0] data,
                          input logic e, input logic r, input logic f);
    set_in(0, v, data, e, r, f);
    set_in(1, v, data, e, r, f);
  endtask

  // Records this cycle's accepts/flushes in the model, then advances to the next negedge.
  task automatic tick();
    #4;
    for (int d = 0; d < 2; d++) begin
      if (reset_n) begin
        if (fl[d]) expq[d].delete();
        else if (iv[d] && ir[d]) expq[d].push_back({ie[d], id[d]});
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      m_err[d] = 1'b0;
      m_stall[d] = 0;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset_n = 1'b0;
    clear_model();
    set_both(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    tick();

    // Pass-through, back-to-back.
    set_both(1'b1, 8'h11, 1'b0, 1'b1, 1'b0); tick();
    set_both(1'b1, 8'h22, 1'b0, 1'b1, 1'b0); tick();
    set_both(1'b1, 8'h33, 1'b0, 1'b1, 1'b0); tick();
    set_both(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick(); tick();

    // Back-pressure fill.
    set_both(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0); tick();
    set_both(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0); tick();
    set_both(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    set_both(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick(); tick(); tick();

    // Full stage with out_ready toggling.
    for (int i = 0; i < 8; i++) begin
      set_both(1'b1, 8'(8'h40 + i), 1'b0, i[0], 1'b0);
      tick();
    end
    set_both(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick(); tick(); tick();

    // Flush with simultaneous accept and transfer of an err beat.
    set_both(1'b1, 8'hE1, 1'b1, 1'b0, 1'b0); tick();
    set_both(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0); tick();
    set_both(1'b1, 8'hE3, 1'b0, 1'b1, 1'b1); tick();
    set_both(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick(); tick();

    // Asynchronous reset mid-stream while full.
    set_both(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0); tick();
    set_both(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0); tick();
    set_both(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    clear_model();
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    set_both(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0); tick();
    set_both(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick(); tick();

    // Stall counter saturation.
    set_both(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      set_both(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_both(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick(); tick(); tick();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        set_in(d, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      end
      tick();
    end
    set_both(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick(); tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
